// File: rtl/game_over_ctrl.sv
// Game-flow controller for the bird column: start/play/crash/over sequencing,
// collision and pipe-pass detection on each game tick, and a saturating score.
module game_over_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CRASH_TICKS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              groundIn,
    input  logic [DATA_W-1:0] birdRow,
    input  logic [DATA_W-1:0] pipeRow,
    input  logic              startKey,
    output logic              lossDetect,
    output logic              playing,
    output logic [7:0]        score,
    output logic              over
);

    localparam int CNT_W = $clog2(CRASH_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  crash_cnt;
    logic [DATA_W-1:0] pipe_prev;
    logic              start_hist;
    logic              start_edge;
    logic              collision;
    logic              pipe_pass;
    logic              crash_last;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign start_edge = startKey & ~start_hist;
    assign collision  = groundIn | (|(birdRow & pipeRow));
    assign pipe_pass  = (|pipe_prev) & ~(|pipeRow);
    // A count of 0 in CRASH cannot normally occur; treat it as finished too.
    assign crash_last = (crash_cnt <= CNT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) state_next = PLAY;
            end
            PLAY: begin
                if (tick && collision) state_next = CRASH;
            end
            CRASH: begin
                if (tick && crash_last) state_next = OVER;
            end
            OVER: begin
                if (start_edge) state_next = PLAY;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        playing = 1'b0;
        over    = 1'b0;
        case (state)
            PLAY:    playing = 1'b1;
            OVER:    over    = 1'b1;
            default: ;
        endcase
    end

    // Score, crash timer, previous-tick pipe column and start-key history.
    always_ff @(posedge clock) begin
        if (reset) begin
            score      <= 8'd0;
            crash_cnt  <= '0;
            pipe_prev  <= '0;
            start_hist <= 1'b1;
            lossDetect <= 1'b0;
        end else begin
            start_hist <= startKey;
            lossDetect <= (state_next == CRASH);
            case (state)
                IDLE, OVER: begin
                    if (start_edge) begin
                        score     <= 8'd0;
                        pipe_prev <= '0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        pipe_prev <= pipeRow;
                        if (collision) begin
                            crash_cnt <= CNT_W'(CRASH_TICKS);
                        end else if (pipe_pass) begin
                            score <= sat_inc(score);
                        end
                    end
                end
                CRASH: begin
                    if (tick && crash_cnt != '0) crash_cnt <= crash_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
